// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-side port B initiator of the I/D BRAM.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_RESP    = 2'b10
  } lsu_state_e;

  // Byte-lane write enables for an access of the given size at a byte offset.
  function automatic logic [3:0] byte_mask(input mem_size_e size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SZ_B:    mask = 4'b0001 << offset;
      SZ_H:    mask = 4'b0011 << offset;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_lsu_port_load_align.sv
// Combinational load aligner: picks the addressed lanes out of a BRAM word and extends them.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // Shift the addressed byte down to lane 0, then truncate and extend.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    case (size)
      SZ_B: begin
        if (is_unsigned) begin
          result = {24'h000000, shifted_s[7:0]};
        end else begin
          result = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SZ_H: begin
        if (is_unsigned) begin
          result = {16'h0000, shifted_s[15:0]};
        end else begin
          result = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      SZ_W:    result = shifted_s;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_port.sv
// Core LSU to BRAM port B initiator: one request at a time, absorbs the one-cycle read latency.
module dmem_lsu_port
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e  state_r, state_next_s;
  mem_size_e   size_s, size_r;
  logic [1:0]  off_r;
  logic        uns_r;
  logic        accept_s, err_s;
  logic        rsp_valid_r, rsp_err_r;
  logic [31:0] rsp_rdata_r, align_s;

  assign size_s   = mem_size_e'(req_size);
  assign accept_s = req_valid & req_ready;

  // Request legality: size, natural alignment and BRAM address range.
  always_comb begin
    err_s = 1'b0;
    case (size_s)
      SZ_B:    err_s = 1'b0;
      SZ_H:    err_s = req_addr[0];
      SZ_W:    err_s = |req_addr[1:0];
      default: err_s = 1'b1;
    endcase
    if (|req_addr[31:ADDR_WIDTH]) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = (err_s || req_we) ? ST_RESP : ST_RD_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: state_next_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: BRAM strobes only in the accepting cycle of a legal request.
  always_comb begin
    req_ready = (state_r == ST_IDLE);
    mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    if (accept_s && !err_s) begin
      mem_en = 1'b1;
      mem_we = req_we ? byte_mask(size_s, req_addr[1:0]) : 4'b0000;
    end else begin
      mem_en = 1'b0;
      mem_we = 4'b0000;
    end
    case (size_s)
      SZ_B:    mem_wdata = {4{req_wdata[7:0]}};
      SZ_H:    mem_wdata = {2{req_wdata[15:0]}};
      default: mem_wdata = req_wdata;
    endcase
  end

  // Load attributes needed one cycle later by the aligner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r  <= 2'b00;
      size_r <= SZ_B;
      uns_r  <= 1'b0;
    end else if (accept_s && !err_s && !req_we) begin
      off_r  <= req_addr[1:0];
      size_r <= size_s;
      uns_r  <= req_unsigned;
    end
  end

  load_align u_load_align (
    .rdata       (mem_rdata),
    .offset      (off_r),
    .size        (size_r),
    .is_unsigned (uns_r),
    .result      (align_s)
  );

  // Response registers; held unchanged while waiting in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= (state_next_s == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= err_s;
          end
        end
        ST_RD_WAIT: begin
          rsp_rdata_r <= align_s;
          rsp_err_r   <= 1'b0;
        end
        default: begin
          rsp_rdata_r <= rsp_rdata_r;
          rsp_err_r   <= rsp_err_r;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Self-checking bench for dmem_lsu_port with a behavioural port-B BRAM model.
module tb_dmem_lsu_port;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] bram [0:8191];
  logic [32:0] exp_q [$];

  dmem_lsu_port #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM port B: byte-lane writes, registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) bram[mem_addr[14:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= bram[mem_addr[14:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        en;
    logic [3:0]  mwe;
    logic [14:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic [32:0] e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    #1;
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, {31'd0, v.en});
    chk({tag, "_mem_we"}, {28'd0, mem_we}, {28'd0, v.mwe});
    if (v.en) chk({tag, "_mem_addr"}, {17'd0, mem_addr}, {17'd0, v.maddr});
    if (v.en && v.we) chk({tag, "_mem_wdata"}, mem_wdata, v.mwdata);
    exp_q.push_back({v.err, v.rdata});
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      chk({tag, "_no_en_wait"}, {31'd0, mem_en}, 32'd0);
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    if (!rsp_valid) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      chk({tag, "_latency"}, lat, v.lat);
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) bram[i] = 32'h0000_0000;
    mem_rdata = 32'h0000_0000;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b1;

    nvec = 0;
    vecs[nvec++] = '{1'b1, 32'h0100, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 4'b1111, 15'h0100, 32'hDEADBEEF, 32'h0, 1'b0, 1};
    vecs[nvec++] = '{1'b0, 32'h0100, 2'b10, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h0100, 32'h0, 32'hDEADBEEF, 1'b0, 2};
    vecs[nvec++] = '{1'b0, 32'h0103, 2'b00, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h0100, 32'h0, 32'hFFFFFFDE, 1'b0, 2};
    vecs[nvec++] = '{1'b0, 32'h0103, 2'b00, 1'b1, 32'h0, 1'b1, 4'b0000, 15'h0100, 32'h0, 32'h000000DE, 1'b0, 2};
    vecs[nvec++] = '{1'b0, 32'h0102, 2'b01, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h0100, 32'h0, 32'hFFFFDEAD, 1'b0, 2};
    vecs[nvec++] = '{1'b0, 32'h0100, 2'b01, 1'b1, 32'h0, 1'b1, 4'b0000, 15'h0100, 32'h0, 32'h0000BEEF, 1'b0, 2};
    vecs[nvec++] = '{1'b1, 32'h0202, 2'b01, 1'b0, 32'h00001234, 1'b1, 4'b1100, 15'h0200, 32'h12341234, 32'h0, 1'b0, 1};
    vecs[nvec++] = '{1'b0, 32'h0202, 2'b01, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h0200, 32'h0, 32'h00001234, 1'b0, 2};
    vecs[nvec++] = '{1'b1, 32'h0301, 2'b00, 1'b0, 32'h000000A5, 1'b1, 4'b0010, 15'h0300, 32'hA5A5A5A5, 32'h0, 1'b0, 1};
    vecs[nvec++] = '{1'b0, 32'h0300, 2'b10, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h0300, 32'h0, 32'h0000A500, 1'b0, 2};
    vecs[nvec++] = '{1'b0, 32'h0301, 2'b00, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h0300, 32'h0, 32'hFFFFFFA5, 1'b0, 2};
    vecs[nvec++] = '{1'b1, 32'h7FFE, 2'b01, 1'b0, 32'hFFFF8001, 1'b1, 4'b1100, 15'h7FFC, 32'h80018001, 32'h0, 1'b0, 1};
    vecs[nvec++] = '{1'b0, 32'h7FFE, 2'b01, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h7FFC, 32'h0, 32'hFFFF8001, 1'b0, 2};
    vecs[nvec++] = '{1'b0, 32'h0101, 2'b01, 1'b0, 32'h0, 1'b0, 4'b0000, 15'h0, 32'h0, 32'h0, 1'b1, 1};
    vecs[nvec++] = '{1'b0, 32'h0102, 2'b10, 1'b0, 32'h0, 1'b0, 4'b0000, 15'h0, 32'h0, 32'h0, 1'b1, 1};
    vecs[nvec++] = '{1'b0, 32'h0100, 2'b11, 1'b0, 32'h0, 1'b0, 4'b0000, 15'h0, 32'h0, 32'h0, 1'b1, 1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);
    // Out-of-range word load and out-of-range byte store.
    run_vec('{1'b0, 32'h00008000, 2'b10, 1'b0, 32'h0, 1'b0, 4'b0000, 15'h0, 32'h0, 32'h0, 1'b1, 1}, 100);
    run_vec('{1'b1, 32'h10000004, 2'b00, 1'b0, 32'h55, 1'b0, 4'b0000, 15'h0, 32'h0, 32'h0, 1'b1, 1}, 101);

    // Back-pressure: load held in RESP while a store waits at the request side.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0100; req_size = 2'b10; req_unsigned = 1'b0;
    #1;
    chk("bp_accept_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("bp_no_mem_en", {31'd0, mem_en}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      if (i >= 1) begin
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_done_ready", {31'd0, req_ready}, 32'd1);
    run_vec('{1'b0, 32'h0100, 2'b10, 1'b0, 32'h0, 1'b1, 4'b0000, 15'h0100, 32'h0, 32'hDEADBEEF, 1'b0, 2}, 200);

    // Reset while in RD_WAIT: transaction dropped, no stale response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0200; req_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    end
    run_vec('{1'b0, 32'h0202, 2'b01, 1'b1, 32'h0, 1'b1, 4'b0000, 15'h0200, 32'h0, 32'h00001234, 1'b0, 2}, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_port.md
# dmem_lsu_port

Data-side initiator for port B of the shared 32 KB instruction/data BRAM. Accepts one load/store request at a time from the core LSU over a valid/ready channel. Drives the BRAM's byte-addressed, word-wide port (enable, byte write mask, address, write data) and absorbs its one-cycle registered read latency. Returns aligned, sign- or zero-extended load data, or an error, over a valid/ready response channel.

## Interface
- ADDR_WIDTH, 15, BRAM byte-address width (2^15 = 32 KB)
- DATA_WIDTH, 32, BRAM word width; only 32 is supported
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid & ready
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size or out-of-range access
- mem_en  out  1  to BRAM enb
- mem_we  out  4  to BRAM web, bit i = byte lane i
- mem_addr  out  ADDR_WIDTH  to BRAM addrb; always word-aligned, bits [1:0] = 0
- mem_wdata  out  32  to BRAM dinb
- mem_rdata  in  32  from BRAM doutb; registered, valid the cycle after mem_en

## Operation
- FSM states: IDLE, RD_WAIT, RESP. req_ready = (state == IDLE).
- Accept in cycle T with req_valid & req_ready. The request is checked combinationally:
  - err if req_size == 11.
  - err if half and addr[0] != 0.
  - err if word and addr[1:0] != 0.
  - err if req_addr[31:ADDR_WIDTH] != 0.
- Error: mem_en stays 0 and the BRAM is not touched. Go to RESP with rsp_err = 1 and rsp_rdata = 0.
- Store: in cycle T, mem_en = 1, mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Byte store: mem_we = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - Half store: mem_we = 0011 << addr[1:0], mem_wdata = {2{wdata[15:0]}}.
  - Word store: mem_we = 1111, mem_wdata = wdata.
  - Then go to RESP with rsp_err = 0 and rsp_rdata = 0.
- Load: in cycle T, mem_en = 1, mem_we = 0000, same word address. Go to RD_WAIT and register offset, size and unsigned.
- RD_WAIT: shift mem_rdata right by 8*offset. Truncate to the size, then sign- or zero-extend into rsp_rdata. Go to RESP.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_ready, go to IDLE.
- mem_en and mem_we are combinational, gated by acceptance, and are 0 in every other cycle.
- mem_addr and mem_wdata are don't-care when mem_en = 0. Drive them from req_* to avoid extra muxing.

## Timing
- Reset (async assert, sync deassert handled upstream) gives: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_en = 0, mem_we = 0000. req_ready = 1 from the first cycle after reset.
- Store or error: accepted at T, rsp_valid rises at T+1.
- Load: accepted at T, BRAM samples at the end of T, mem_rdata is valid in T+1, rsp_valid rises at T+2.
- Throughput: one request per 2 cycles for stores/errors and 3 cycles for loads, with rsp_ready held high. No back-to-back accept while a response is pending.
- Back-pressure: rsp_ready low holds RESP indefinitely. req_ready stays 0 and no BRAM access is issued.
- Reset mid-operation (RD_WAIT or RESP): the transaction is dropped and no response is produced. A store already issued in T has committed.
- Port A activity is independent. A same-address conflict with port A is outside this block's scope.

## Structure
- Shared package dmem_pkg holds:
  - typedef enum logic [1:0] mem_size_e {SZ_B, SZ_H, SZ_W, SZ_ILL}
  - the FSM state enum
  - function byte_mask(size, offset)
- One combinational sub-module, load_align: mem_rdata, offset, size, unsigned -> 32-bit result.
- FSM, request checking and response registers live in the top module.

## Test plan
- Word store addr 0x0100, wdata 0xDEADBEEF -> T: mem_en=1, mem_we=1111, mem_addr=0x0100, mem_wdata=0xDEADBEEF; rsp_valid at T+1, rsp_err=0. A later word load of 0x0100 -> rsp_rdata=0xDEADBEEF at T+2.
- Byte load 0x0103, signed, after the store above -> rsp_rdata=0xFFFFFFDE. Same load unsigned -> 0x000000DE.
- Half store 0x0202, wdata 0x1234 -> mem_we=1100, mem_wdata=0x12341234, mem_addr=0x0200. Signed half load 0x0202 -> 0x00001234.
- Half load 0x0101, word load 0x0102, size=11, and addr 0x00008000 each -> mem_en never 1, rsp_err=1, rsp_rdata=0 at T+1.
- Load accepted with rsp_ready=0 for 5 cycles -> rsp_valid and data stable; req_ready=0; no mem_en pulse. Response completes on rsp_ready.
- rst_n asserted in RD_WAIT -> rsp_valid=0 and req_ready=1 after release; no stale response is emitted.
